// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// ALU operations, condition codes and datapath select values.
package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWR  = 4'd5,
        MEMWB  = 4'd6,
        EXECR  = 4'd7,
        EXECI  = 4'd8,
        ALUWB  = 4'd9,
        BRANCH = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Unrecognised commands report as invalid so the controller can suppress their writes.
    function automatic logic [2:0] aluDecode(input logic [3:0] cmd);
        logic [2:0] result;
        case (cmd)
            CMD_ADD: result = {1'b1, ALU_ADD};
            CMD_SUB: result = {1'b1, ALU_SUB};
            CMD_CMP: result = {1'b1, ALU_SUB};
            CMD_AND: result = {1'b1, ALU_AND};
            CMD_ORR: result = {1'b1, ALU_ORR};
            default: result = {1'b0, ALU_ADD};
        endcase
        return result;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Holds the NZCV flag register (with separate NZ / CV write enables) and
// evaluates the instruction condition against the stored flags.
module cond_check
    import ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic [3:0] r_flags;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    // FlagWrite[1] loads N and Z, FlagWrite[0] loads C and V.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= FLAGS_RST;
        end else begin
            if (FlagWrite[1]) r_flags[3:2] <= ALUFlags[3:2];
            if (FlagWrite[0]) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign Flags = r_flags;

    always_comb begin
        CondEx = 1'b0;
        case (cond)
            COND_EQ: CondEx = w_z;
            COND_NE: CondEx = ~w_z;
            COND_CS: CondEx = w_c;
            COND_CC: CondEx = ~w_c;
            COND_MI: CondEx = w_n;
            COND_PL: CondEx = ~w_n;
            COND_VS: CondEx = w_v;
            COND_VC: CondEx = ~w_v;
            COND_HI: CondEx = w_c & ~w_z;
            COND_LS: CondEx = ~w_c | w_z;
            COND_GE: CondEx = (w_n == w_v);
            COND_LT: CondEx = (w_n != w_v);
            COND_GT: CondEx = ~w_z & (w_n == w_v);
            COND_LE: CondEx = w_z | (w_n != w_v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for the multicycle ARM-subset datapath: decodes
// Instr[31:12], sequences each instruction and drives every enable/select.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter bit         MEM_WAIT_EN = 1'b1,
    parameter logic [3:0] FLAGS_RST   = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  state_dbg
);

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_cmd;
    logic       w_rd15;
    logic       w_memReady;
    logic       w_condEx;
    logic [3:0] w_flags;
    logic [1:0] w_flagWrite;
    logic [2:0] w_aluDec;
    logic       w_cmdValid;
    logic [1:0] w_aluCtl;
    logic       w_isCmp;
    logic       w_isAddSub;
    logic [1:0] w_regSrc;
    logic [1:0] w_immSrc;
    logic       w_unusedRn;

    assign w_cond     = Instr[19:16];
    assign w_op       = Instr[15:14];
    assign w_funct    = Instr[13:8];
    assign w_cmd      = w_funct[4:1];
    assign w_rd15     = (Instr[3:0] == 4'hF);
    assign w_unusedRn = ^Instr[7:4];
    assign w_memReady = MEM_WAIT_EN ? mem_ready : 1'b1;

    assign w_aluDec   = aluDecode(w_cmd);
    assign w_cmdValid = w_aluDec[2];
    assign w_aluCtl   = w_aluDec[1:0];
    assign w_isCmp    = (w_cmd == CMD_CMP);
    assign w_isAddSub = (w_cmd == CMD_ADD) || (w_cmd == CMD_SUB) || w_isCmp;

    assign w_regSrc = {(w_op == 2'b01) && !w_funct[0], (w_op == 2'b10)};
    assign w_immSrc = (w_op == 2'b01) ? 2'b01 : (w_op == 2'b10) ? 2'b10 : 2'b00;

    cond_check #(
        .FLAGS_RST(FLAGS_RST)
    ) u_condCheck (
        .clk      (clk),
        .reset    (reset),
        .cond     (w_cond),
        .ALUFlags (ALUFlags),
        .FlagWrite(w_flagWrite),
        .CondEx   (w_condEx),
        .Flags    (w_flags)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    assign state_dbg = r_state;

    // mem_ready reaches the outputs only through the FETCH IRWrite/PCWrite gating.
    always_comb begin
        w_nextState = r_state;
        PCWrite     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        IRWrite     = 1'b0;
        AdrSrc      = 1'b0;
        RegSrc      = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RM;
        ResultSrc   = RES_ALUOUT;
        ImmSrc      = 2'b00;
        ALUControl  = ALU_ADD;
        w_flagWrite = 2'b00;
        case (r_state)
            IDLE: w_nextState = FETCH;
            FETCH: begin
                IRWrite     = w_memReady;
                PCWrite     = w_memReady;
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                w_nextState = w_memReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (w_op)
                    2'b00:   w_nextState = w_funct[5] ? EXECI : EXECR;
                    2'b01:   w_nextState = MEMADR;
                    2'b10:   w_nextState = BRANCH;
                    default: w_nextState = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB     = SRCB_IMM;
                ALUControl  = w_funct[3] ? ALU_ADD : ALU_SUB;
                w_nextState = w_funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc      = 1'b1;
                w_nextState = w_memReady ? MEMWB : MEMRD;
            end
            MEMWR: begin
                AdrSrc      = 1'b1;
                MemWrite    = w_condEx;
                w_nextState = w_memReady ? FETCH : MEMWR;
            end
            MEMWB: begin
                ResultSrc   = RES_READDATA;
                RegWrite    = w_condEx && !w_rd15;
                PCWrite     = w_condEx && w_rd15;
                w_nextState = FETCH;
            end
            EXECR, EXECI: begin
                ALUSrcB     = (r_state == EXECI) ? SRCB_IMM : SRCB_RM;
                ALUControl  = w_aluCtl;
                if (w_condEx && w_cmdValid && (w_funct[0] || w_isCmp))
                    w_flagWrite = {1'b1, w_isAddSub};
                w_nextState = ALUWB;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                if (w_cmdValid && !w_isCmp) begin
                    RegWrite = w_condEx && !w_rd15;
                    PCWrite  = w_condEx && w_rd15;
                end
                w_nextState = FETCH;
            end
            BRANCH: begin
                ALUSrcB     = SRCB_IMM;
                ResultSrc   = RES_ALURESULT;
                PCWrite     = w_condEx;
                w_nextState = FETCH;
            end
            default: w_nextState = IDLE;
        endcase
        if (r_state != IDLE && r_state != FETCH) begin
            RegSrc = w_regSrc;
            ImmSrc = w_immSrc;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: walks DP, branch,
// load/store and NOP sequences, wait states and asynchronous reset.
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUControl;
    logic [3:0]  state_dbg;

    int totalChecks = 0;
    int badChecks   = 0;

    multicycle_controller #(
        .MEM_WAIT_EN(1'b1),
        .FLAGS_RST  (4'b0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Instr     (Instr),
        .ALUFlags  (ALUFlags),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .RegSrc    (RegSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .ALUControl(ALUControl),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [19:0] instr, input logic [3:0] flags, input logic ready);
        Instr     = instr;
        ALUFlags  = flags;
        mem_ready = ready;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        Instr     = 20'h0;
        ALUFlags  = 4'h0;
        mem_ready = 1'b1;

        @(posedge clk);
        #1;
        checkOutput("rst_state", state_dbg, 4'd0);
        checkOutput("rst_enables", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
        checkOutput("rst_selects", {AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl}, 13'h0);
        checkOutput("rst_flags", dut.w_flags, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("idle_after_rel", state_dbg, 4'd0);
        checkOutput("idle_enables", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
        stepCycle();
        checkOutput("first_fetch", state_dbg, 4'd1);

        // ADD R1,R2,R3 with one FETCH wait state first
        applyStimulus(20'hE0821, 4'h0, 1'b0);
        checkOutput("fetch_wait_irw", IRWrite, 1'b0);
        checkOutput("fetch_wait_pcw", PCWrite, 1'b0);
        stepCycle();
        checkOutput("fetch_hold", state_dbg, 4'd1);
        applyStimulus(20'hE0821, 4'h0, 1'b1);
        checkOutput("fetch_enables", {IRWrite, PCWrite, AdrSrc, RegWrite}, 4'b1100);
        checkOutput("fetch_selects", {ALUSrcA, ALUSrcB, ResultSrc, ALUControl}, 7'b1_10_10_00);
        stepCycle();
        checkOutput("add_decode", state_dbg, 4'd2);
        checkOutput("add_dec_regw", RegWrite, 1'b0);
        stepCycle();
        checkOutput("add_execr", state_dbg, 4'd7);
        checkOutput("add_aluctl", ALUControl, 2'b00);
        checkOutput("add_srcb", ALUSrcB, 2'b00);
        checkOutput("add_exec_regw", RegWrite, 1'b0);
        stepCycle();
        checkOutput("add_aluwb", state_dbg, 4'd9);
        checkOutput("add_wb_regw", RegWrite, 1'b1);
        checkOutput("add_wb_res", ResultSrc, 2'b00);
        stepCycle();
        checkOutput("add_back_fetch", state_dbg, 4'd1);

        // SUBS R0,R0,R0 sets Z; then BEQ taken, BNE not taken
        applyStimulus(20'hE0500, 4'b0100, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("subs_aluctl", ALUControl, 2'b01);
        stepCycle();
        checkOutput("subs_flags", dut.w_flags, 4'b0100);
        checkOutput("subs_regw", RegWrite, 1'b1);
        stepCycle();
        applyStimulus(20'h0A000, 4'b0000, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("beq_state", state_dbg, 4'd10);
        checkOutput("beq_pcw", PCWrite, 1'b1);
        checkOutput("beq_imm", {ImmSrc, ALUSrcB}, 4'b1001);
        stepCycle();
        checkOutput("beq_3cyc", state_dbg, 4'd1);
        applyStimulus(20'h1A000, 4'b0000, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("bne_pcw", PCWrite, 1'b0);
        stepCycle();

        // CMP R0,R0 updates NZCV without a register write
        applyStimulus(20'hE1500, 4'b1001, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("cmp_aluctl", ALUControl, 2'b01);
        stepCycle();
        checkOutput("cmp_regw", {RegWrite, PCWrite}, 2'b00);
        checkOutput("cmp_flags", dut.w_flags, 4'b1001);
        stepCycle();

        // NOP takes two cycles
        applyStimulus(20'hEC000, 4'h0, 1'b1);
        stepCycle();
        checkOutput("nop_decode", state_dbg, 4'd2);
        stepCycle();
        checkOutput("nop_fetch", state_dbg, 4'd1);

        // LDR R1,[R0] with three wait cycles in MEMRD
        applyStimulus(20'hE5901, 4'h0, 1'b1);
        stepCycle();
        checkOutput("ldr_immsrc", ImmSrc, 2'b01);
        stepCycle();
        checkOutput("ldr_memadr", state_dbg, 4'd3);
        checkOutput("ldr_adr_sel", {ALUSrcB, ALUControl}, 4'b0100);
        applyStimulus(20'hE5901, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput($sformatf("ldr_memrd%0d", i), {state_dbg, AdrSrc}, {4'd4, 1'b1});
        end
        applyStimulus(20'hE5901, 4'h0, 1'b1);
        stepCycle();
        checkOutput("ldr_memwb", state_dbg, 4'd6);
        checkOutput("ldr_wb_ctl", {ResultSrc, RegWrite, PCWrite}, 4'b0110);
        stepCycle();
        checkOutput("ldr_back_fetch", state_dbg, 4'd1);

        // STR R1,[R0]: MemWrite only in MEMWR
        applyStimulus(20'hE5801, 4'h0, 1'b1);
        stepCycle();
        checkOutput("str_regsrc", RegSrc, 2'b10);
        checkOutput("str_dec_memw", MemWrite, 1'b0);
        stepCycle();
        checkOutput("str_adr_memw", MemWrite, 1'b0);
        stepCycle();
        checkOutput("str_memwr", state_dbg, 4'd5);
        checkOutput("str_wr_ctl", {MemWrite, AdrSrc, RegWrite}, 3'b110);
        stepCycle();
        checkOutput("str_4cyc", {state_dbg, MemWrite}, {4'd1, 1'b0});

        // Reset asserted mid-MEMWR aborts the store immediately
        applyStimulus(20'hE5801, 4'h0, 1'b1);
        stepCycle();
        stepCycle();
        applyStimulus(20'hE5801, 4'h0, 1'b0);
        stepCycle();
        checkOutput("rstwr_memw_pre", MemWrite, 1'b1);
        stepCycle();
        checkOutput("rstwr_hold", state_dbg, 4'd5);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rstwr_memw", MemWrite, 1'b0);
        checkOutput("rstwr_state", state_dbg, 4'd0);
        checkOutput("rstwr_flags", dut.w_flags, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(20'h0, 4'h0, 1'b1);
        stepCycle();
        checkOutput("rstwr_refetch", state_dbg, 4'd1);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
